multdiv_seq: RTL

Iterative signed 32×32 multiply/divide unit for the processor's execute stage. Sequences a 64-bit working register through one left-shift-by-one per cycle:
- shift-add for multiply;
- restoring shift-subtract for divide.

Each operation is launched by a one-cycle control pulse and finishes with a single-cycle ready strobe. The pipeline stalls on the ready strobe.

---
 rtl/multdiv_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_seq.sv
// Iterative signed 32x32 multiply / divide unit: one shift-add or restoring
// shift-subtract step per cycle, a single-cycle ready strobe on completion.
module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [63:0] work_r, acc_r;
    logic [31:0] mag_b_r;
    logic        op_div_r, sign_r, dbz_r;
    logic [31:0] result_r;
    logic        exc_r, rdy_r;

    logic        start_s, is_div_s, dbz_start_s, load_s, rdy_s;
    logic [63:0] acc_step_s, mcand_step_s, div_shift_s, div_step_s, prod_s;
    logic [31:0] quot_mag_s, quot_s, fin_res_s, res_s;
    logic        fin_exc_s, exc_s;

    assign start_s     = ctrl_MULT | ctrl_DIV;
    assign is_div_s    = ctrl_DIV & ~ctrl_MULT;
    assign dbz_start_s = is_div_s & (data_operandB == 32'd0);

    // One datapath step and the value the result would take if this step is the last
    always_comb begin
        acc_step_s   = mag_b_r[cnt_r] ? (acc_r + work_r) : acc_r;
        mcand_step_s = {work_r[62:0], 1'b0};
        div_shift_s  = {work_r[62:0], 1'b0};
        if (div_shift_s[63:32] >= mag_b_r) begin
            div_step_s = {div_shift_s[63:32] - mag_b_r, div_shift_s[31:1], 1'b1};
        end else begin
            div_step_s = div_shift_s;
        end
        prod_s     = sign_r ? (~acc_step_s + 64'd1) : acc_step_s;
        quot_mag_s = div_step_s[31:0];
        quot_s     = sign_r ? (~quot_mag_s + 32'd1) : quot_mag_s;
        if (dbz_r) begin
            fin_res_s = 32'd0;
            fin_exc_s = 1'b1;
        end else if (op_div_r) begin
            // Only +2^31 (from -2^31 / -1) is out of range for a quotient
            fin_res_s = quot_s;
            fin_exc_s = ~sign_r & quot_mag_s[31];
        end else begin
            fin_res_s = prod_s[31:0];
            fin_exc_s = (prod_s[63:32] != {32{prod_s[31]}});
        end
    end

    // Next-state and result-load decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        res_s   = fin_res_s;
        exc_s   = fin_exc_s;
        case (state_r)
            IDLE, RUN: begin
                if (start_s) begin
                    if (dbz_start_s) begin
                        state_s = DONE;
                        load_s  = 1'b1;
                        res_s   = 32'd0;
                        exc_s   = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else if ((state_r == RUN) && (cnt_r == 5'd31)) begin
                    state_s = DONE;
                    load_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            // A divide-by-zero launched here runs the full sequence so the
            // ready strobe can never be high on two consecutive cycles
            DONE: begin
                if (start_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign rdy_s = (state_s == DONE);

    // Control state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            result_r <= 32'd0;
            exc_r    <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            rdy_r   <= rdy_s;
            if (load_s) begin
                result_r <= res_s;
                exc_r    <= exc_s;
            end else begin
                result_r <= result_r;
                exc_r    <= exc_r;
            end
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= 5'd0;
            work_r   <= 64'd0;
            acc_r    <= 64'd0;
            mag_b_r  <= 32'd0;
            op_div_r <= 1'b0;
            sign_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (start_s) begin
            cnt_r    <= 5'd0;
            work_r   <= {32'd0, abs32(data_operandA)};
            acc_r    <= 64'd0;
            mag_b_r  <= abs32(data_operandB);
            op_div_r <= is_div_s;
            sign_r   <= data_operandA[31] ^ data_operandB[31];
            dbz_r    <= dbz_start_s;
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + 5'd1;
            if (op_div_r) begin
                work_r <= div_step_s;
            end else begin
                work_r <= mcand_step_s;
                acc_r  <= acc_step_s;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign data_result    = result_r;
    assign data_exception = exc_r;
    assign data_resultRDY = rdy_r;

endmodule
